// File: rtl/cache_ctrl_fsm_p.sv
// Direct-mapped cache controller: hit/miss compare, dirty-line write-back and line fill.
// Memory reads return a fixed MEM_LAT cycles after issue, whether or not m_stall is asserted.
module cache_ctrl_fsm_p #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int WORDS   = 4,
  parameter int MEM_LAT = 2,
  parameter int INDEX_W = 8,
  localparam int OFF_W  = $clog2(WORDS),
  localparam int TAG_W  = ADDR_W - INDEX_W - OFF_W - 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd,
  input  logic               wr,
  input  logic [ADDR_W-1:0]  addr,
  input  logic [DATA_W-1:0]  data_in,
  output logic [DATA_W-1:0]  data_out,
  output logic               done,
  output logic               cache_hit,
  output logic               err,
  output logic               stall,
  input  logic               c_hit,
  input  logic               c_valid,
  input  logic               c_dirty,
  input  logic [TAG_W-1:0]   c_tag_out,
  input  logic [DATA_W-1:0]  c_data_out,
  output logic               c_enable,
  output logic               c_comp,
  output logic               c_write,
  output logic               c_valid_in,
  output logic [TAG_W-1:0]   c_tag_in,
  output logic [INDEX_W-1:0] c_index,
  output logic [OFF_W-1:0]   c_offset,
  output logic [DATA_W-1:0]  c_data_in,
  output logic               m_rd,
  output logic               m_wr,
  output logic [ADDR_W-1:0]  m_addr,
  output logic [DATA_W-1:0]  m_data_in,
  input  logic [DATA_W-1:0]  m_data_out,
  input  logic               m_stall
);

  // state | meaning
  // IDLE  | waiting for a single rd or wr strobe
  // COMP  | tag compare / hit access with the latched request
  // WB    | writing the dirty victim line back, one word per accepted cycle
  // FILL  | issuing line reads and writing returned words into the array
  // RETRY | second compare after the fill; a hit here is not reported as a cache hit
  typedef enum logic [2:0] {IDLE, COMP, WB, FILL, RETRY} state_t;

  localparam logic [OFF_W-1:0] LAST_OFF = OFF_W'(WORDS - 1);

  state_t state, state_nxt;

  logic               req_wr;
  logic [TAG_W-1:0]   req_tag;
  logic [INDEX_W-1:0] req_index;
  logic [OFF_W-1:0]   req_off;
  logic [DATA_W-1:0]  req_data;

  logic [OFF_W-1:0]   wb_cnt;
  logic [OFF_W:0]     issue_cnt;
  logic [OFF_W-1:0]   ret_cnt;
  logic [MEM_LAT-1:0] pipe_v;
  logic [OFF_W-1:0]   pipe_off [MEM_LAT];
  logic               err_q;

  logic               issue;
  logic               ret;
  logic [OFF_W-1:0]   ret_off;
  logic               addr_unused;

  assign addr_unused = addr[0];
  assign issue   = m_rd && !m_stall;
  assign ret     = pipe_v[MEM_LAT-1];
  assign ret_off = pipe_off[MEM_LAT-1];
  assign stall   = (state != IDLE);
  assign err     = err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      req_wr    <= 1'b0;
      req_tag   <= '0;
      req_index <= '0;
      req_off   <= '0;
      req_data  <= '0;
      wb_cnt    <= '0;
      issue_cnt <= '0;
      ret_cnt   <= '0;
      pipe_v    <= '0;
      err_q     <= 1'b0;
      for (int i = 0; i < MEM_LAT; i++) pipe_off[i] <= '0;
    end else begin
      state <= state_nxt;
      err_q <= (state == IDLE) && rd && wr;
      if ((state == IDLE) && (rd ^ wr)) begin
        req_wr    <= wr;
        req_tag   <= addr[ADDR_W-1 -: TAG_W];
        req_index <= addr[INDEX_W+OFF_W -: INDEX_W];
        req_off   <= addr[OFF_W:1];
        req_data  <= data_in;
      end
      if (state != WB) wb_cnt <= '0;
      else if (!m_stall) wb_cnt <= wb_cnt + 1'b1;
      if (state != FILL) begin
        issue_cnt <= '0;
        ret_cnt   <= '0;
      end else begin
        if (issue) issue_cnt <= issue_cnt + 1'b1;
        if (ret) ret_cnt <= ret_cnt + 1'b1;
      end
      // return pipeline: slot MEM_LAT-1 lines up with m_data_out for that read
      pipe_v[0]   <= issue;
      pipe_off[0] <= issue_cnt[OFF_W-1:0];
      for (int i = 1; i < MEM_LAT; i++) begin
        pipe_v[i]   <= pipe_v[i-1];
        pipe_off[i] <= pipe_off[i-1];
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    data_out   = '0;
    done       = 1'b0;
    cache_hit  = 1'b0;
    c_enable   = 1'b0;
    c_comp     = 1'b0;
    c_write    = 1'b0;
    c_valid_in = 1'b0;
    c_tag_in   = req_tag;
    c_index    = req_index;
    c_offset   = '0;
    c_data_in  = '0;
    m_rd       = 1'b0;
    m_wr       = 1'b0;
    m_addr     = '0;
    m_data_in  = '0;
    case (state)
      IDLE: begin
        if (rd ^ wr) state_nxt = COMP;
      end
      COMP, RETRY: begin
        c_enable   = 1'b1;
        c_comp     = 1'b1;
        c_write    = req_wr;
        c_valid_in = req_wr;
        c_offset   = req_off;
        c_data_in  = req_data;
        if (c_hit && c_valid) begin
          done      = 1'b1;
          cache_hit = (state == COMP);
          data_out  = c_data_out;
          state_nxt = IDLE;
        end else if ((state == COMP) && c_valid && c_dirty) begin
          state_nxt = WB;
        end else begin
          state_nxt = FILL;
        end
      end
      WB: begin
        c_enable  = 1'b1;
        c_offset  = wb_cnt;
        m_wr      = 1'b1;
        m_addr    = {c_tag_out, req_index, wb_cnt, 1'b0};
        m_data_in = c_data_out;
        if (!m_stall && (wb_cnt == LAST_OFF)) state_nxt = FILL;
      end
      FILL: begin
        if (!issue_cnt[OFF_W]) begin
          m_rd   = 1'b1;
          m_addr = {req_tag, req_index, issue_cnt[OFF_W-1:0], 1'b0};
        end
        if (ret) begin
          c_enable   = 1'b1;
          c_write    = 1'b1;
          c_valid_in = 1'b1;
          c_offset   = ret_off;
          c_data_in  = m_data_out;
          if (ret_cnt == LAST_OFF) state_nxt = RETRY;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_ctrl_fsm_p.sv
// Scoreboard bench for cache_ctrl_fsm_p (WORDS=4, MEM_LAT=2): stimulus pushes expected
// done/err, memory, cache-write and cycle-probe records; a negedge monitor pops and compares.
module tb_cache_ctrl_fsm_p;
  localparam int ADDR_W = 16, DATA_W = 16, WORDS = 4, MEM_LAT = 2, INDEX_W = 8;
  localparam int OFF_W = 2, TAG_W = 5;

  logic clk = 1'b0;
  logic rst, rd, wr, m_stall, c_dirty;
  logic [15:0] addr, data_in, data_out, c_data_out, m_data_out, m_addr, m_data_in, c_data_in;
  logic done, cache_hit, err, stall, c_hit, c_valid;
  logic [TAG_W-1:0] c_tag_out, c_tag_in;
  logic [INDEX_W-1:0] c_index;
  logic [OFF_W-1:0] c_offset;
  logic c_enable, c_comp, c_write, c_valid_in, m_rd, m_wr;

  cache_ctrl_fsm_p #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WORDS(WORDS), .MEM_LAT(MEM_LAT),
                     .INDEX_W(INDEX_W)) dut (
    .clk(clk), .rst(rst), .rd(rd), .wr(wr), .addr(addr), .data_in(data_in),
    .data_out(data_out), .done(done), .cache_hit(cache_hit), .err(err), .stall(stall),
    .c_hit(c_hit), .c_valid(c_valid), .c_dirty(c_dirty), .c_tag_out(c_tag_out),
    .c_data_out(c_data_out), .c_enable(c_enable), .c_comp(c_comp), .c_write(c_write),
    .c_valid_in(c_valid_in), .c_tag_in(c_tag_in), .c_index(c_index), .c_offset(c_offset),
    .c_data_in(c_data_in), .m_rd(m_rd), .m_wr(m_wr), .m_addr(m_addr),
    .m_data_in(m_data_in), .m_data_out(m_data_out), .m_stall(m_stall));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // cache array model: word = base + offset; line becomes a hit once 4 fill writes land
  logic [15:0] base;
  logic hit_mode, valid_mode;
  int fill_writes = 0;
  int fill_base = 0;
  assign c_data_out = base + {14'b0, c_offset};
  assign c_hit   = hit_mode   || ((fill_writes - fill_base) >= 4);
  assign c_valid = valid_mode || ((fill_writes - fill_base) >= 4);
  always @(posedge clk) if (c_write && !c_comp) fill_writes <= fill_writes + 1;

  // memory model: read data = address ^ A5A5, returned two cycles after acceptance
  logic [15:0] mq0 = 16'h0, mq1 = 16'h0;
  always @(posedge clk) begin
    mq1 <= mq0;
    mq0 <= (m_rd && !m_stall) ? (m_addr ^ 16'hA5A5) : 16'h0;
  end
  assign m_data_out = mq1;

  typedef struct {int cyc; bit is_err; bit hit; bit chk_data; logic [15:0] data;} done_t;
  typedef struct {bit wr; logic [15:0] addr; logic [15:0] data;} mem_t;
  typedef struct {bit comp; logic [1:0] off; logic [15:0] data; logic [4:0] tag; logic [7:0] idx;} cw_t;
  typedef struct {int cyc; bit stall; bit quiet; bit zero;} probe_t;

  done_t  dq[$];
  mem_t   mq[$];
  cw_t    cwq[$];
  probe_t pq[$];

  int n_cmp = 0;
  int n_bad = 0;
  bit end_req = 1'b0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // monitor
  initial begin
    done_t d;
    mem_t m;
    cw_t w;
    probe_t p;
    bit prev_wait;
    logic [15:0] prev_addr, prev_data;
    prev_wait = 1'b0;
    prev_addr = '0;
    prev_data = '0;
    forever begin
      @(negedge clk);
      if (end_req) begin
        chk("done_queue_empty", 32'(dq.size()), 0);
        chk("mem_queue_empty", 32'(mq.size()), 0);
        chk("cwr_queue_empty", 32'(cwq.size()), 0);
        chk("probe_queue_empty", 32'(pq.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
      end
      if (done || err) begin
        if (dq.size() == 0) chk("unexpected_done_err", 1, 0);
        else begin
          d = dq.pop_front();
          chk("done_cycle", 32'(cyc), 32'(d.cyc));
          chk("err_kind", 32'(err), 32'(d.is_err));
          chk("done_kind", 32'(done), 32'(!d.is_err));
          if (!d.is_err) chk("cache_hit", 32'(cache_hit), 32'(d.hit));
          if (d.chk_data) chk("data_out", 32'(data_out), 32'(d.data));
        end
      end else if (dq.size() > 0 && dq[0].cyc < cyc) begin
        d = dq.pop_front();
        chk("done_missing", 1, 0);
      end
      if (m_rd || m_wr) begin
        chk("m_rd_wr_excl", 32'(m_rd & m_wr), 0);
        if (prev_wait && m_wr) begin
          chk("wb_hold_addr", 32'(m_addr), 32'(prev_addr));
          chk("wb_hold_data", 32'(m_data_in), 32'(prev_data));
        end
        if (!m_stall) begin
          if (mq.size() == 0) chk("unexpected_mem", 1, 0);
          else begin
            m = mq.pop_front();
            chk("mem_is_wr", 32'(m_wr), 32'(m.wr));
            chk("mem_addr", 32'(m_addr), 32'(m.addr));
            if (m.wr) chk("mem_wdata", 32'(m_data_in), 32'(m.data));
          end
        end
      end else begin
        chk("m_addr_idle", 32'(m_addr), 0);
      end
      prev_wait = m_wr && m_stall;
      prev_addr = m_addr;
      prev_data = m_data_in;
      if (c_write) begin
        if (cwq.size() == 0) chk("unexpected_cwrite", 1, 0);
        else begin
          w = cwq.pop_front();
          chk("cw_comp", 32'(c_comp), 32'(w.comp));
          chk("cw_offset", 32'(c_offset), 32'(w.off));
          chk("cw_data", 32'(c_data_in), 32'(w.data));
          chk("cw_valid_in", 32'(c_valid_in), 1);
          chk("cw_tag", 32'(c_tag_in), 32'(w.tag));
          chk("cw_index", 32'(c_index), 32'(w.idx));
        end
      end
      while (pq.size() > 0 && pq[0].cyc <= cyc) begin
        p = pq.pop_front();
        chk("probe_cycle", 32'(cyc), 32'(p.cyc));
        chk("stall", 32'(stall), 32'(p.stall));
        if (p.quiet) chk("quiet", 32'({m_rd, m_wr, c_write, c_enable, done}), 0);
        if (p.zero) chk("all_outputs_zero", 32'(|{data_out, done, cache_hit, err, stall,
            c_enable, c_comp, c_write, c_valid_in, c_tag_in, c_index, c_offset, c_data_in,
            m_rd, m_wr, m_addr, m_data_in}), 0);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // stimulus
  initial begin
    int a;
    rst = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; data_in = '0; m_stall = 1'b0;
    c_dirty = 1'b0; c_tag_out = '0; hit_mode = 1'b0; valid_mode = 1'b0; base = '0;

    tick(1);
    pq.push_back('{1, 1'b0, 1'b0, 1'b1});
    pq.push_back('{2, 1'b0, 1'b0, 1'b1});
    tick(2);
    rst = 1'b1;
    pq.push_back('{cyc, 1'b0, 1'b1, 1'b1});
    pq.push_back('{cyc + 1, 1'b0, 1'b1, 1'b0});
    tick(2);

    // read hit at 0x1234 (tag 2, index 0x46, offset 2)
    a = cyc; fill_base = fill_writes; hit_mode = 1'b1; valid_mode = 1'b1; base = 16'hBEEF;
    rd = 1'b1; addr = 16'h1234;
    dq.push_back('{a + 1, 1'b0, 1'b1, 1'b1, 16'hBEF1});
    pq.push_back('{a + 1, 1'b1, 1'b0, 1'b0});
    pq.push_back('{a + 2, 1'b0, 1'b1, 1'b0});
    tick(1); rd = 1'b0;
    tick(3); hit_mode = 1'b0; valid_mode = 1'b0;

    // clean read miss
    a = cyc; fill_base = fill_writes; base = 16'h7000;
    rd = 1'b1; addr = 16'h1234;
    for (int k = 0; k < 4; k++) begin
      mq.push_back('{1'b0, 16'h1230 + 16'(2 * k), 16'h0});
      cwq.push_back('{1'b0, 2'(k), (16'h1230 + 16'(2 * k)) ^ 16'hA5A5, 5'd2, 8'h46});
    end
    dq.push_back('{a + 8, 1'b0, 1'b0, 1'b1, 16'h7002});
    pq.push_back('{a + 8, 1'b1, 1'b0, 1'b0});
    pq.push_back('{a + 9, 1'b0, 1'b1, 1'b0});
    tick(1); rd = 1'b0;
    tick(10);

    // dirty write miss, victim tag 5: write-back to 0x2A30..0x2A36
    a = cyc; fill_base = fill_writes; valid_mode = 1'b1; c_dirty = 1'b1; c_tag_out = 5'd5;
    base = 16'hD000; wr = 1'b1; addr = 16'h1234; data_in = 16'h5A5A;
    cwq.push_back('{1'b1, 2'd2, 16'h5A5A, 5'd2, 8'h46});
    for (int k = 0; k < 4; k++) mq.push_back('{1'b1, 16'h2A30 + 16'(2 * k), 16'hD000 + 16'(k)});
    for (int k = 0; k < 4; k++) begin
      mq.push_back('{1'b0, 16'h1230 + 16'(2 * k), 16'h0});
      cwq.push_back('{1'b0, 2'(k), (16'h1230 + 16'(2 * k)) ^ 16'hA5A5, 5'd2, 8'h46});
    end
    cwq.push_back('{1'b1, 2'd2, 16'h5A5A, 5'd2, 8'h46});
    dq.push_back('{a + 12, 1'b0, 1'b0, 1'b0, 16'h0});
    pq.push_back('{a + 12, 1'b1, 1'b0, 1'b0});
    pq.push_back('{a + 13, 1'b0, 1'b1, 1'b0});
    tick(1); wr = 1'b0;
    tick(14);

    // dirty write miss with m_stall held 3 cycles on write-back word 2
    a = cyc; fill_base = fill_writes; base = 16'h3300; wr = 1'b1; data_in = 16'h0F0F;
    cwq.push_back('{1'b1, 2'd2, 16'h0F0F, 5'd2, 8'h46});
    for (int k = 0; k < 4; k++) mq.push_back('{1'b1, 16'h2A30 + 16'(2 * k), 16'h3300 + 16'(k)});
    for (int k = 0; k < 4; k++) begin
      mq.push_back('{1'b0, 16'h1230 + 16'(2 * k), 16'h0});
      cwq.push_back('{1'b0, 2'(k), (16'h1230 + 16'(2 * k)) ^ 16'hA5A5, 5'd2, 8'h46});
    end
    cwq.push_back('{1'b1, 2'd2, 16'h0F0F, 5'd2, 8'h46});
    dq.push_back('{a + 15, 1'b0, 1'b0, 1'b0, 16'h0});
    pq.push_back('{a + 15, 1'b1, 1'b0, 1'b0});
    pq.push_back('{a + 16, 1'b0, 1'b1, 1'b0});
    tick(1); wr = 1'b0;
    tick(3); m_stall = 1'b1;
    tick(3); m_stall = 1'b0;
    tick(12);
    c_dirty = 1'b0; valid_mode = 1'b0;

    // rd and wr together: err only, nothing latched
    a = cyc; rd = 1'b1; wr = 1'b1; addr = 16'h0F00;
    dq.push_back('{a + 1, 1'b1, 1'b0, 1'b0, 16'h0});
    pq.push_back('{a + 1, 1'b0, 1'b1, 1'b0});
    pq.push_back('{a + 2, 1'b0, 1'b1, 1'b0});
    tick(1); rd = 1'b0; wr = 1'b0;
    tick(3);

    // write hit at 0xABCE (tag 0x15, index 0x79, offset 3)
    a = cyc; hit_mode = 1'b1; valid_mode = 1'b1; wr = 1'b1; addr = 16'hABCE; data_in = 16'h1111;
    cwq.push_back('{1'b1, 2'd3, 16'h1111, 5'h15, 8'h79});
    dq.push_back('{a + 1, 1'b0, 1'b1, 1'b0, 16'h0});
    pq.push_back('{a + 2, 1'b0, 1'b1, 1'b0});
    tick(1); wr = 1'b0;
    tick(3); hit_mode = 1'b0; valid_mode = 1'b0;

    // reset in the middle of a fill: one read accepted, its return is dropped
    a = cyc; fill_base = fill_writes; rd = 1'b1; addr = 16'h1234;
    mq.push_back('{1'b0, 16'h1230, 16'h0});
    tick(1); rd = 1'b0;
    tick(2); rst = 1'b0;
    pq.push_back('{a + 3, 1'b0, 1'b0, 1'b1});
    pq.push_back('{a + 4, 1'b0, 1'b0, 1'b1});
    tick(2); rst = 1'b1;
    pq.push_back('{a + 5, 1'b0, 1'b1, 1'b1});
    pq.push_back('{a + 6, 1'b0, 1'b1, 1'b0});
    pq.push_back('{a + 7, 1'b0, 1'b1, 1'b0});
    tick(6);

    end_req = 1'b1;
    tick(3);
    $display("FAIL monitor_finish: got no summary expected summary");
    $fatal(1);
  end

endmodule
